joy_serial_reader: RTL and testbench
====================================

JOY_SERIAL_READER -- requirements
Module: joy_serial_reader

Interface
REQ-001 Parameter CLK_DIV, default 48, means clk cycles per tick (one half bit period); legal range 4..1023.
REQ-002 Parameter FRAME_GAP, default 16, means idle ticks between frames; legal range 1..1023.
REQ-003 clk  input  1  system clock (40-50 MHz).
REQ-004 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 JOY_DATA  input  1  serial pad data, active-low buttons, asynchronous to clk.
REQ-006 JOY_CLK  output  1  shift clock to external shift-register chain.
REQ-007 JOY_LOAD  output  1  parallel-load strobe, active-low.
REQ-008 joystick1  output  16  player 1 state, active-high: [11:0] = {L,S,F,E,D,C,B,A,U,D,L,R} order as shifted, [15:12] = 0.
REQ-009 joystick2  output  16  player 2 state, same layout as joystick1.
REQ-010 frame_done  output  1  one-cycle pulse when joystick1/2 update.

Function
REQ-011 Tick counter counts 0..CLK_DIV-1 and wraps; tick is asserted in the cycle the counter equals CLK_DIV-1; every state transition occurs on a tick.
REQ-012 JOY_DATA passes through a 2-flop synchroniser; all samples use the synchronised value.
REQ-013 States: LOAD, SHIFT_LO, SHIFT_HI, LATCH, GAP.
REQ-014 LOAD: JOY_LOAD=0, JOY_CLK=1, duration 1 tick, then SHIFT_LO with bit index 0.
REQ-015 SHIFT_LO: JOY_LOAD=1, JOY_CLK=0, duration 1 tick; on its ending tick sample synchronised JOY_DATA into bit[index], then SHIFT_HI.
REQ-016 SHIFT_HI: JOY_CLK=1, duration 1 tick; on ending tick, if index=23 go LATCH, else index+1 and go SHIFT_LO.
REQ-017 Bits 0..11 map to joystick1[11:0], bits 12..23 map to joystick2[11:0]; stored value is the inverse of the sampled wire level.
REQ-018 LATCH lasts exactly one clk cycle (not tick-gated): outputs updated, frame_done=1, tick counter cleared, then GAP.
REQ-019 GAP: JOY_LOAD=1, JOY_CLK=1 for FRAME_GAP ticks, then LOAD.
REQ-020 Frame period = (1 + 48 + FRAME_GAP) x CLK_DIV + 1 clk cycles; default 3121.
REQ-021 joystick1/2 hold their value between LATCH events; a partially shifted frame never reaches the outputs.
REQ-022 JOY_CLK and JOY_LOAD are registered outputs, glitch-free, never both low.

Reset
REQ-023 While reset_n=0: JOY_LOAD=1, JOY_CLK=1, joystick1=0, joystick2=0, frame_done=0, tick counter=0, index=0, synchroniser=1, state=GAP with gap count set so LOAD begins on the first tick after release.
REQ-024 Reset asserted mid-frame aborts the frame within one cycle; outputs go to reset values, no frame_done.

Configuration
REQ-025 Macro JOY_DEBOUNCE_EN: when defined, LATCH updates joystick1/2 only for bits whose shifted value equals the previous frame's shifted value (two consecutive agreeing frames required); frame_done still pulses every frame; previous-frame register resets to 0.
REQ-026 Without JOY_DEBOUNCE_EN, LATCH copies the shifted frame directly to outputs.

Verification
REQ-027 Reset release, CLK_DIV=4, FRAME_GAP=2 -> JOY_LOAD low for cycles 4..7 after release, 24 JOY_CLK low pulses of 4 cycles each, frame_done after 4x(1+48)+... per REQ-020 period 205 cycles.
REQ-028 Pad model drives bits 0..23 = ~24'h00A_5C3 -> joystick1=16'h05C3? no: joystick1=16'h05C3 low 12 bits = 12'h5C3, joystick2=16'h000A, frame_done single pulse.
REQ-029 All-high JOY_DATA (no buttons) -> joystick1=joystick2=16'h0000; bits [15:12] stay 0 under all-low JOY_DATA (outputs 16'h0FFF).
REQ-030 reset_n low at bit 10 of frame -> outputs 0, JOY_LOAD=JOY_CLK=1 next cycle, next complete frame latches correctly.
REQ-031 JOY_DEBOUNCE_EN defined, P1 bit R pressed for one frame only -> joystick1[0] stays 0; pressed two consecutive frames -> joystick1[0]=1 at second frame_done.
REQ-032 Toggle JOY_DATA asynchronously mid-tick -> no change to JOY_CLK/JOY_LOAD timing; sampled bit equals level 2 cycles before sampling tick.

Source files
------------

// File: rtl/joy_serial_reader.sv
// joy_serial_reader: polls two 12-button pads through an external
// parallel-load shift-register chain (24 bits per frame) and presents the
// decoded, active-high button state together with a per-frame strobe.
// Optional build macro JOY_DEBOUNCE_EN: a button bit only changes at the
// outputs after two consecutive frames agree on its new value.
module joy_serial_reader #(
    parameter int CLK_DIV   = 48,
    parameter int FRAME_GAP = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        frame_done
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int GW = $clog2(FRAME_GAP + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(FRAME_GAP - 1);
    localparam logic [4:0]    LAST_BIT  = 5'd23;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_GAP
    } state_t;

    state_t          state_reg;
    logic [TW-1:0]   tick_cnt_reg;
    logic            tick;
    logic [GW-1:0]   gap_cnt_reg;
    logic [4:0]      bit_idx_reg;
    logic [1:0]      sync_reg;
    logic [23:0]     shift_reg;
    logic [23:0]     pad_state_reg;
    logic [23:0]     latch_next;
    logic            joy_clk_reg;
    logic            joy_load_reg;
    logic            frame_done_reg;
`ifdef JOY_DEBOUNCE_EN
    logic [23:0]     prev_frame_reg;
`endif

    assign tick = (tick_cnt_reg == TICK_LAST);

    // Half-bit-period timebase; restarted by LATCH so GAP begins on a clean tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt_reg <= '0;
        end else if (tick || state_reg == ST_LATCH) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous pad data line (idles high).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], JOY_DATA};
        end
    end

    // Next output word: either the fresh frame or, with debounce, only the
    // bits that matched the previous frame, the rest holding their old state.
    generate
        for (genvar gi = 0; gi < 24; gi++) begin : g_merge
`ifdef JOY_DEBOUNCE_EN
            assign latch_next[gi] = (shift_reg[gi] == prev_frame_reg[gi]) ?
                                    shift_reg[gi] : pad_state_reg[gi];
`else
            assign latch_next[gi] = shift_reg[gi];
`endif
        end
    endgenerate

    // Frame sequencer: drives the pad strobes and collects the 24 bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= ST_GAP;
            gap_cnt_reg    <= '0;
            bit_idx_reg    <= '0;
            joy_clk_reg    <= 1'b1;
            joy_load_reg   <= 1'b1;
            frame_done_reg <= 1'b0;
            shift_reg      <= '0;
            pad_state_reg  <= '0;
`ifdef JOY_DEBOUNCE_EN
            prev_frame_reg <= '0;
`endif
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_LOAD: begin
                    if (tick) begin
                        state_reg    <= ST_SHIFT_LO;
                        bit_idx_reg  <= '0;
                        joy_load_reg <= 1'b1;
                        joy_clk_reg  <= 1'b0;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick) begin
                        // Pad lines are active-low; store pressed as 1.
                        shift_reg[bit_idx_reg] <= ~sync_reg[1];
                        state_reg   <= ST_SHIFT_HI;
                        joy_clk_reg <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        if (bit_idx_reg == LAST_BIT) begin
                            state_reg <= ST_LATCH;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 5'd1;
                            state_reg   <= ST_SHIFT_LO;
                            joy_clk_reg <= 1'b0;
                        end
                    end
                end
                ST_LATCH: begin
                    pad_state_reg  <= latch_next;
`ifdef JOY_DEBOUNCE_EN
                    prev_frame_reg <= shift_reg;
`endif
                    frame_done_reg <= 1'b1;
                    gap_cnt_reg    <= GAP_LAST;
                    state_reg      <= ST_GAP;
                end
                ST_GAP: begin
                    if (tick) begin
                        if (gap_cnt_reg == '0) begin
                            state_reg    <= ST_LOAD;
                            joy_load_reg <= 1'b0;
                            joy_clk_reg  <= 1'b1;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg - GW'(1);
                        end
                    end
                end
                default: begin
                    state_reg    <= ST_GAP;
                    gap_cnt_reg  <= '0;
                    joy_load_reg <= 1'b1;
                    joy_clk_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign JOY_CLK    = joy_clk_reg;
    assign JOY_LOAD   = joy_load_reg;
    assign frame_done = frame_done_reg;
    assign joystick1  = {4'h0, pad_state_reg[11:0]};
    assign joystick2  = {4'h0, pad_state_reg[23:12]};

endmodule

// File: tb/tb_joy_serial_reader.sv
// Testbench for joy_serial_reader with CLK_DIV=4, FRAME_GAP=2 and a
// behavioural parallel-load shift-register pad chain. Extra checks are
// enabled when the design is built with JOY_DEBOUNCE_EN.
module tb_joy_serial_reader;

    localparam int CLK_DIV   = 4;
    localparam int FRAME_GAP = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        JOY_DATA;
    logic        JOY_CLK;
    logic        JOY_LOAD;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    logic [23:0] pad_bits = 24'hFFFFFF;
    int          pad_idx  = 24;
    logic        pad_level;
    logic        ovr_en  = 1'b0;
    logic        ovr_val = 1'b1;

    always #5 clk = ~clk;

    joy_serial_reader #(
        .CLK_DIV   (CLK_DIV),
        .FRAME_GAP (FRAME_GAP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .JOY_DATA   (JOY_DATA),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .frame_done (frame_done)
    );

    // Pad chain: load strobe presents bit 0, each rising shift clock advances.
    always @(negedge JOY_LOAD or posedge JOY_CLK) begin
        if (!JOY_LOAD) pad_idx = 0;
        else if (JOY_CLK) pad_idx = pad_idx + 1;
    end

    always @* begin
        pad_level = (pad_idx >= 0 && pad_idx < 24) ? pad_bits[pad_idx] : 1'b1;
        JOY_DATA  = ovr_en ? ovr_val : pad_level;
    end

    typedef struct {
        logic [23:0] pressed;
        logic [15:0] exp1;
        logic [15:0] exp2;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 1000);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL %s: no frame_done within %0d cycles, required a pulse", name, n);
        end
    endtask

    task automatic wait_load_low(input string name);
        int n;
        n = 0;
        while (JOY_LOAD && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (JOY_LOAD) begin
            checks++;
            errors++;
            $display("FAIL %s: JOY_LOAD never went low, got 1 required 0", name);
        end
    endtask

    task automatic wait_clk_falls(input int count, input string name);
        int n;
        int falls;
        logic prev;
        n = 0;
        falls = 0;
        prev = JOY_CLK;
        while (falls < count && n < 1000) begin
            @(negedge clk);
            n++;
            if (prev && !JOY_CLK) falls++;
            prev = JOY_CLK;
        end
        if (falls < count) begin
            checks++;
            errors++;
            $display("FAIL %s: saw %0d JOY_CLK falls, required %0d", name, falls, count);
        end
    endtask

    initial begin
        logic [11:0] load_trace;
        int falls, lows, both_low, pulses, first_at, second_at, fd_in_reset;
        logic prev_clk;
        logic [15:0] f1j1, f1j2, f2j1, f2j2;

        vecs[0] = '{24'h000000, 16'h0000, 16'h0000};
        vecs[1] = '{24'hFFFFFF, 16'h0FFF, 16'h0FFF};
        vecs[2] = '{24'h00A5C3, 16'h05C3, 16'h000A};
        vecs[3] = '{24'h123456, 16'h0456, 16'h0123};
        vecs[4] = '{24'h800001, 16'h0001, 16'h0800};
        vecs[5] = '{24'hFFF000, 16'h0000, 16'h0FFF};
        vecs[6] = '{24'h000FFF, 16'h0FFF, 16'h0000};

        // Reset state
        pad_bits = ~24'h00A5C3;
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_load", JOY_LOAD, 1'b1);
        chk("rst_clk", JOY_CLK, 1'b1);
        chk("rst_j1", joystick1, 16'h0000);
        chk("rst_j2", joystick2, 16'h0000);
        chk("rst_done", frame_done, 1'b0);

        // Frame timing after release
        reset_n = 1'b1;
        load_trace = '0;
        falls = 0; lows = 0; both_low = 0; pulses = 0; first_at = 0; second_at = 0;
        f1j1 = '0; f1j2 = '0; f2j1 = '0; f2j2 = '0;
        prev_clk = 1'b1;
        for (int n = 1; n <= 410; n++) begin
            @(negedge clk);
            if (n <= 12) load_trace[n-1] = JOY_LOAD;
            if (n <= 201 && prev_clk && !JOY_CLK) falls++;
            if (n <= 201 && !JOY_CLK) lows++;
            if (!JOY_CLK && !JOY_LOAD) both_low++;
            if (frame_done) begin
                pulses++;
                if (pulses == 1) begin
                    first_at = n; f1j1 = joystick1; f1j2 = joystick2;
                end else if (pulses == 2) begin
                    second_at = n; f2j1 = joystick1; f2j2 = joystick2;
                end
            end
            prev_clk = JOY_CLK;
        end
        chk("load_window", load_trace, 12'hF87);
        chk("clk_pulses", falls, 24);
        chk("clk_low_cycles", lows, 96);
        chk("never_both_low", both_low, 0);
        chk("first_done_cycle", first_at, 201);
        chk("frame_period", second_at - first_at, 205);
        chk("done_pulses", pulses, 2);
`ifndef JOY_DEBOUNCE_EN
        chk("frame1_j1", f1j1, 16'h05C3);
        chk("frame1_j2", f1j2, 16'h000A);
`endif
        chk("frame2_j1", f2j1, 16'h05C3);
        chk("frame2_j2", f2j2, 16'h000A);
        $display("timing: first frame_done at cycle %0d, period %0d", first_at, second_at - first_at);

        // Table of pad patterns, each held for two frames
        wait_frame("align");
        for (int i = 0; i < 7; i++) begin
            pad_bits = ~vecs[i].pressed;
            wait_frame($sformatf("vec%0d_f1", i));
`ifndef JOY_DEBOUNCE_EN
            chk($sformatf("vec%0d_f1_j1", i), joystick1, vecs[i].exp1);
            chk($sformatf("vec%0d_f1_j2", i), joystick2, vecs[i].exp2);
`endif
            wait_frame($sformatf("vec%0d_f2", i));
            chk($sformatf("vec%0d_j1", i), joystick1, vecs[i].exp1);
            chk($sformatf("vec%0d_j2", i), joystick2, vecs[i].exp2);
            $display("vec %0d pressed=%h j1=%h j2=%h", i, vecs[i].pressed, joystick1, joystick2);
        end

`ifdef JOY_DEBOUNCE_EN
        // Single-frame press is filtered, two-frame press is accepted
        pad_bits = ~24'h000000;
        wait_frame("db_idle1");
        wait_frame("db_idle2");
        chk("db_idle_j1", joystick1, 16'h0000);
        pad_bits = ~24'h000001;
        wait_frame("db_glitch");
        chk("db_glitch_j1", joystick1, 16'h0000);
        pad_bits = ~24'h000000;
        wait_frame("db_release");
        chk("db_release_j1", joystick1, 16'h0000);
        pad_bits = ~24'h000001;
        wait_frame("db_press1");
        chk("db_press1_j1", joystick1, 16'h0000);
        wait_frame("db_press2");
        chk("db_press2_j1", joystick1, 16'h0001);
        $display("debounce: j1=%h after two pressed frames", joystick1);
`endif

        // Reset in the middle of a frame
        pad_bits = ~24'h00A5C3;
        wait_frame("pre_rst1");
        wait_frame("pre_rst2");
        chk("pre_rst_j1", joystick1, 16'h05C3);
        wait_load_low("midrst_load");
        wait_clk_falls(11, "midrst_bit10");
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_load", JOY_LOAD, 1'b1);
        chk("midrst_clk", JOY_CLK, 1'b1);
        chk("midrst_j1", joystick1, 16'h0000);
        chk("midrst_j2", joystick2, 16'h0000);
        fd_in_reset = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (frame_done) fd_in_reset++;
        end
        chk("midrst_no_done", fd_in_reset, 0);
        reset_n = 1'b1;
        wait_frame("post_rst1");
`ifndef JOY_DEBOUNCE_EN
        chk("post_rst1_j1", joystick1, 16'h05C3);
        chk("post_rst1_j2", joystick2, 16'h000A);
`endif
        wait_frame("post_rst2");
        chk("post_rst2_j1", joystick1, 16'h05C3);
        chk("post_rst2_j2", joystick2, 16'h000A);
        $display("mid-frame reset: recovered j1=%h j2=%h", joystick1, joystick2);

`ifndef JOY_DEBOUNCE_EN
        // Synchroniser latency: level two cycles before the sampling edge wins
        pad_bits = 24'hFFFFFF;
        wait_frame("sync_align");
        wait_load_low("sync_a_load");
        wait_clk_falls(1, "sync_a_fall");
        @(negedge clk);
        ovr_val = 1'b0;
        ovr_en  = 1'b1;
        repeat (3) @(negedge clk);
        ovr_en  = 1'b0;
        wait_frame("sync_a_frame");
        chk("sync_early_j1", joystick1, 16'h0001);
        chk("sync_early_j2", joystick2, 16'h0000);
        wait_load_low("sync_b_load");
        wait_clk_falls(1, "sync_b_fall");
        repeat (2) @(negedge clk);
        ovr_en  = 1'b1;
        repeat (2) @(negedge clk);
        ovr_en  = 1'b0;
        wait_frame("sync_b_frame");
        chk("sync_late_j1", joystick1, 16'h0000);
        $display("sync: late toggle gave j1=%h", joystick1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
